load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 146 ++++++++++++++
 tb/tb_load_store_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit with sub-word extension and read-modify-write stores; LSU_MISALIGN_TRAP_EN enables misalignment faults
module load_store_unit #(
    parameter int ADDR_BITS = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_write,
    output logic        mem_read,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_result
);

    typedef enum logic [1:0] {IDLE, ISSUE, LOAD_DONE, RMW_WRITE} state_t;

    state_t      state, state_next;
    logic        is_write_q;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic [31:0] wdata_q;
    logic        fault_q;
    logic [31:0] address_q;

    logic        accept;
    logic        code_ok;
    logic        req_fault;
    logic [1:0]  aligned_off;
    logic        unused_addr;

    assign accept      = req_valid && req_ready;
    assign unused_addr = ^req_addr[31:ADDR_BITS+2];

    // Half and word offsets are rounded down to natural alignment.
    always_comb begin
        code_ok     = req_write ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                                : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        aligned_off = req_addr[1:0];
        case (req_funct3[1:0])
            2'b01:   aligned_off = {req_addr[1], 1'b0};
            2'b10:   aligned_off = 2'b00;
            default: aligned_off = req_addr[1:0];
        endcase
`ifdef LSU_MISALIGN_TRAP_EN
        req_fault = !code_ok
                 || (req_funct3[1:0] == 2'b01 && req_addr[0])
                 || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`else
        req_fault = !code_ok;
`endif
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            is_write_q <= 1'b0;
            funct3_q   <= 3'b000;
            offset_q   <= 2'b00;
            wdata_q    <= 32'h0;
            fault_q    <= 1'b0;
            address_q  <= 32'h0;
        end else begin
            state <= state_next;
            if (accept) begin
                is_write_q <= req_write;
                funct3_q   <= req_funct3;
                offset_q   <= aligned_off;
                wdata_q    <= req_wdata;
                fault_q    <= req_fault;
                address_q  <= {{(32-ADDR_BITS){1'b0}}, req_addr[ADDR_BITS+1:2]};
            end
        end
    end

    logic [31:0] shifted;
    logic [31:0] load_data;
    logic [3:0]  lane_mask;
    logic [31:0] store_lanes;
    logic [31:0] merged;

    always_comb begin
        shifted = mem_result >> {offset_q, 3'b000};
        case (funct3_q[1:0])
            2'b00:   load_data = {{24{!funct3_q[2] & shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = {{16{!funct3_q[2] & shifted[15]}}, shifted[15:0]};
            default: load_data = mem_result;
        endcase
        lane_mask   = (funct3_q[1:0] == 2'b00) ? (4'b0001 << offset_q) : (4'b0011 << offset_q);
        store_lanes = (funct3_q[1:0] == 2'b00) ? {4{wdata_q[7:0]}} : {2{wdata_q[15:0]}};
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = lane_mask[i] ? store_lanes[8*i +: 8] : mem_result[8*i +: 8];
        end
    end

    always_comb begin
        state_next     = state;
        req_ready      = (state == IDLE) && reset;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        resp_valid     = 1'b0;
        resp_fault     = 1'b0;
        resp_rdata     = 32'h0;
        mem_address    = address_q;
        mem_write_data = wdata_q;
        case (state)
            IDLE: begin
                if (accept) state_next = ISSUE;
            end
            ISSUE: begin
                if (fault_q) begin
                    resp_valid = 1'b1;
                    resp_fault = 1'b1;
                    state_next = IDLE;
                end else if (is_write_q && funct3_q[1:0] == 2'b10) begin
                    mem_write  = 1'b1;
                    resp_valid = 1'b1;
                    state_next = IDLE;
                end else begin
                    mem_read   = 1'b1;
                    state_next = is_write_q ? RMW_WRITE : LOAD_DONE;
                end
            end
            LOAD_DONE: begin
                resp_valid = 1'b1;
                resp_rdata = load_data;
                state_next = IDLE;
            end
            RMW_WRITE: begin
                mem_write      = 1'b1;
                resp_valid     = 1'b1;
                mem_write_data = merged;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit with a 32-word memory model
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_result;
    logic        mem_init;
    logic [31:0] mem [32];

    int pass_count = 0;
    int total_count = 0;

    always #5 clock = ~clock;

    load_store_unit #(.ADDR_BITS(5)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_write(mem_write), .mem_read(mem_read), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_result(mem_result)
    );

    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= i;
        end else begin
            if (mem_write) mem[mem_address[4:0]] <= mem_write_data;
            if (mem_read) mem_result <= mem[mem_address[4:0]];
        end
    end

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          nw;
        int          nr;
        logic [31:0] maddr;
        logic [31:0] mdata;
    } vec_t;

    vec_t vecs[16];
    vec_t exp_q[$];

    function automatic vec_t mk(logic wr, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                                logic [31:0] rdata, logic fault, int lat, int nw, int nr,
                                logic [31:0] maddr, logic [31:0] mdata);
        vec_t v;
        v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.fault = fault; v.lat = lat; v.nw = nw; v.nr = nr; v.maddr = maddr; v.mdata = mdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_count++;
        if (act === exp) pass_count++;
        else $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    endtask

    // Drive one request, push its expectation, then pop and compare when resp_valid appears.
    task automatic run_vec(input vec_t v, input int idx);
        vec_t e;
        int nw = 0, nr = 0, lat = 0, both = 0, badaddr = 0, baddata = 0;
        logic got = 1'b0;
        @(negedge clock);
        check($sformatf("v%0d_ready", idx), {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_write = v.wr; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
        @(posedge clock);
        exp_q.push_back(v);
        @(negedge clock);
        req_valid = 1'b0;
        for (int c = 1; c <= 4 && !got; c++) begin
            if (c > 1) @(negedge clock);
            if (mem_write) nw++;
            if (mem_read) nr++;
            if (mem_write && mem_read) both++;
            if ((mem_write || mem_read) && mem_address !== v.maddr) badaddr++;
            if (mem_write && mem_write_data !== v.mdata) baddata++;
            if (resp_valid) begin
                got = 1'b1;
                lat = c;
            end
        end
        check($sformatf("v%0d_resp_seen", idx), {31'h0, got}, 32'h1);
        if (got && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("v%0d_rdata", idx), resp_rdata, e.rdata);
            check($sformatf("v%0d_fault", idx), {31'h0, resp_fault}, {31'h0, e.fault});
            check($sformatf("v%0d_latency", idx), lat, e.lat);
            check($sformatf("v%0d_writes", idx), nw, e.nw);
            check($sformatf("v%0d_reads", idx), nr, e.nr);
            check($sformatf("v%0d_strobe_addr", idx), badaddr, 0);
            check($sformatf("v%0d_write_data", idx), baddata, 0);
            check($sformatf("v%0d_exclusive", idx), both, 0);
        end
    endtask

    initial begin
        int acc, wr, rv, rd, bad;
        reset = 1'b0; mem_init = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_funct3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;

        vecs[0]  = mk(0, 3'b010, 32'h14, 32'h0,        32'h00000005, 0, 2, 0, 1, 32'd5, 32'h0);
        vecs[1]  = mk(1, 3'b010, 32'h08, 32'hDEADBEEF, 32'h0,        0, 1, 1, 0, 32'd2, 32'hDEADBEEF);
        vecs[2]  = mk(0, 3'b100, 32'h0B, 32'h0,        32'h000000DE, 0, 2, 0, 1, 32'd2, 32'h0);
        vecs[3]  = mk(0, 3'b000, 32'h0B, 32'h0,        32'hFFFFFFDE, 0, 2, 0, 1, 32'd2, 32'h0);
        vecs[4]  = mk(0, 3'b001, 32'h08, 32'h0,        32'hFFFFBEEF, 0, 2, 0, 1, 32'd2, 32'h0);
        vecs[5]  = mk(0, 3'b101, 32'h0A, 32'h0,        32'h0000DEAD, 0, 2, 0, 1, 32'd2, 32'h0);
        vecs[6]  = mk(1, 3'b000, 32'h0D, 32'h000000AA, 32'h0,        0, 2, 1, 1, 32'd3, 32'h0000AA03);
        vecs[7]  = mk(0, 3'b010, 32'h0C, 32'h0,        32'h0000AA03, 0, 2, 0, 1, 32'd3, 32'h0);
        vecs[8]  = mk(1, 3'b001, 32'h12, 32'hFFFF1234, 32'h0,        0, 2, 1, 1, 32'd4, 32'h12340004);
        vecs[9]  = mk(0, 3'b010, 32'h10, 32'h0,        32'h12340004, 0, 2, 0, 1, 32'd4, 32'h0);
        vecs[10] = mk(0, 3'b001, 32'h12, 32'h0,        32'h00001234, 0, 2, 0, 1, 32'd4, 32'h0);
        vecs[11] = mk(0, 3'b011, 32'h00, 32'h0,        32'h0,        1, 1, 0, 0, 32'd0, 32'h0);
        vecs[12] = mk(1, 3'b100, 32'h04, 32'h11,       32'h0,        1, 1, 0, 0, 32'd1, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[13] = mk(0, 3'b010, 32'h06, 32'h0,        32'h0,        1, 1, 0, 0, 32'd1, 32'h0);
        vecs[15] = mk(0, 3'b101, 32'h0D, 32'h0,        32'h0,        1, 1, 0, 0, 32'd3, 32'h0);
`else
        vecs[13] = mk(0, 3'b010, 32'h06, 32'h0,        32'h00000001, 0, 2, 0, 1, 32'd1, 32'h0);
        vecs[15] = mk(0, 3'b101, 32'h0D, 32'h0,        32'h0000AA03, 0, 2, 0, 1, 32'd3, 32'h0);
`endif
        vecs[14] = mk(0, 3'b000, 32'h8D, 32'h0,        32'hFFFFFFAA, 0, 2, 0, 1, 32'd3, 32'h0);

        repeat (3) @(posedge clock);
        @(negedge clock);
        mem_init = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        check("rst_ready", {31'h0, req_ready}, 32'h1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_strobes", {30'h0, mem_write, mem_read}, 32'h0);
        check("rst_mem_address", mem_address, 32'h0);
        check("rst_mem_write_data", mem_write_data, 32'h0);
        check("rst_rdata_fault", resp_rdata | {31'h0, resp_fault}, 32'h0);

        for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

        // Reset lands during T+1 of a sub-word store; the write half must never happen.
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000; req_addr = 32'h0D; req_wdata = 32'h55;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        check("rstmid_read_t1", {31'h0, mem_read}, 32'h1);
        reset = 1'b0;
        @(negedge clock);
        bad = int'(mem_write) + int'(resp_valid);
        reset = 1'b1;
        @(negedge clock);
        check("rstmid_ready_after", {31'h0, req_ready}, 32'h1);
        for (int c = 0; c < 3; c++) begin
            bad += int'(mem_write) + int'(resp_valid);
            @(negedge clock);
        end
        check("rstmid_no_write_resp", bad, 0);
        run_vec(mk(0, 3'b010, 32'h0C, 32'h0, 32'h0000AA03, 0, 2, 0, 1, 32'd3, 32'h0), 16);

        // Word stores with req_valid held high: one accept every two cycles.
        @(negedge clock);
        acc = 0; wr = 0; rv = 0; rd = 0;
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h1C; req_wdata = 32'h0BADF00D;
        for (int c = 0; c < 12; c++) begin
            if (req_ready) acc++;
            if (mem_write) wr++;
            if (resp_valid) rv++;
            if (mem_read) rd++;
            @(negedge clock);
        end
        req_valid = 1'b0;
        check("b2b_accepts", acc, 6);
        check("b2b_writes", wr, 6);
        check("b2b_responses", rv, 6);
        check("b2b_no_reads", rd, 0);
        run_vec(mk(0, 3'b010, 32'h1C, 32'h0, 32'h0BADF00D, 0, 2, 0, 1, 32'd7, 32'h0), 17);

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
